branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Sits at the EX/MEM boundary and resolves each branch or jump leaving EX.
- Compares the actual outcome with the prediction carried down the pipe, and on a mispredict issues a fetch redirect.
- Drives the BTB write port (ex_mem_pc, update_btb, actual_target).
- Owns a 32-entry 2-bit branch history table (BHT) that fetch reads combinationally to qualify BTB hits, plus branch/mispredict performance counters.

Parameters:
- ENTRY, 32, number of BHT entries.
- INDEX, 5, BHT index width; index = pc[INDEX+1:2].
- PC_W, 12, PC/target width.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pc_in  in  PC_W  fetch PC, used for BHT lookup.
- bht_taken  out  1  combinational: bht[pc_in[6:2]][1].
- ex_valid  in  1  EX holds a valid instruction.
- ex_flush  in  1  kill the EX instruction (wrong path).
- stall  in  1  MEM not advancing.
- ex_is_branch  in  1  conditional branch.
- ex_is_jump  in  1  JAL/JALR.
- ex_pc  in  PC_W  instruction PC.
- ex_taken  in  1  branch condition result; ignored for jumps.
- ex_target  in  PC_W  computed target.
- ex_pred_hit  in  1  BTB hit at fetch.
- ex_pred_taken  in  1  fetch redirected to the predicted target.
- ex_pred_target  in  PC_W  predicted target.
- ex_mem_pc  out  PC_W  registered ex_pc; feeds BTB ex_mem_pc_in.
- update_btb  out  2  00 none, 01 write/update, 10 clear.
- actual_target  out  PC_W  registered ex_target.
- redirect_valid  out  1  mispredict; fetch must load redirect_pc.
- redirect_pc  out  PC_W  correct next PC.
- branch_count  out  CNT_W  resolved branches plus jumps.
- mispredict_count  out  CNT_W  mispredicts.

Behaviour:
- Reset: all BHT entries = 2'b01; ex_mem_pc, actual_target, redirect_pc = 0; update_btb = 00; redirect_valid = 0; both counters = 0. Reset mid-operation discards any in-flight result.
- Qualifier: act = ex_valid & ~ex_flush & ~stall & (ex_is_branch | ex_is_jump). If ex_is_branch and ex_is_jump are both set, treat the instruction as a jump.
- Actual taken: at = ex_is_jump | ex_taken.
- Mispredict:
  - mp = at & (~ex_pred_taken | ex_pred_target != ex_target)
  - mp |= ~at & ex_pred_taken
- Redirect PC: at ? ex_target : ex_pc + 4, truncated mod 2^PC_W (0xFFC + 4 = 0x000).
- BTB action:
  - 01 if at & (~ex_pred_hit | ex_pred_target != ex_target).
  - 10 if ~at & ex_pred_hit & ex_is_branch & the pre-update counter <= 01.
  - 00 otherwise.
- Latency: all outputs are registered, 1 cycle after the act cycle.
- Non-act cycle (bubble, flush, or stall): update_btb <= 00, redirect_valid <= 0. ex_mem_pc, actual_target and redirect_pc hold their previous values.
- BHT:
  - Updates only when act & ex_is_branch: saturating +1 if taken, -1 if not (range 00..11).
  - Jumps never touch the BHT.
  - Write lands at the clock edge; a same-cycle pc_in read of the same index returns the old value.
- Counters:
  - branch_count += 1 on every act.
  - mispredict_count += 1 on act & mp.
  - Both saturate at all-ones, with no wrap.
- redirect_valid is a 1-cycle pulse per mispredict. The younger-instruction flush is driven by the pipeline control, not by this block.

Test Plan:
1. Reset, then sweep pc_in -> bht_taken = 0 for every index; all outputs 0.
2. Branch at ex_pc=0x040, ex_taken=1, ex_target=0x080, pred_hit=0, pred_taken=0 -> next cycle:
   - ex_mem_pc = 0x040, update_btb = 01, actual_target = 0x080
   - redirect_valid = 1, redirect_pc = 0x080
   - bht_taken for pc_in = 0x040 becomes 1
   - branch_count = 1, mispredict_count = 1
3. Repeat #2 twice with pred_hit=1, pred_taken=1, pred_target=0x080 -> update_btb = 00, redirect_valid = 0; counter saturates at 11; mispredict_count stays 1.
4. Not-taken branch at 0x040 with pred_hit=1, pred_taken=1, after driving its counter to 01 -> update_btb = 10, redirect_pc = 0x044, counter = 00.
5. JALR at 0x100, target 0x200, pred_hit=1, pred_target=0x1F0 -> update_btb = 01, redirect_pc = 0x200; BHT entry for 0x100 unchanged at 01.
6. Valid branch with stall=1, then with ex_flush=1:
   - update_btb = 00, redirect_valid = 0; counters and BHT unchanged.
   - Assert reset during a redirect cycle -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves each branch or jump leaving EX against the
// prediction carried from fetch. It raises a one-cycle fetch redirect on a
// mispredict and drives the BTB write port. It also owns the 2-bit branch
// history table that fetch reads, and the branch/mispredict counters.
module branch_resolve_unit #(
    parameter int ENTRY = 32,
    parameter int INDEX = 5,
    parameter int PC_W  = 12,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  pc_in,
    output logic             bht_taken,
    input  logic             ex_valid,
    input  logic             ex_flush,
    input  logic             stall,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic             ex_taken,
    input  logic [PC_W-1:0]  ex_target,
    input  logic             ex_pred_hit,
    input  logic             ex_pred_taken,
    input  logic [PC_W-1:0]  ex_pred_target,
    output logic [PC_W-1:0]  ex_mem_pc,
    output logic [1:0]       update_btb,
    output logic [PC_W-1:0]  actual_target,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    typedef enum logic [1:0] {
        BTB_NONE  = 2'b00,
        BTB_WRITE = 2'b01,
        BTB_CLEAR = 2'b10
    } btb_op_e;

    logic [1:0]       bht [ENTRY];
    logic [INDEX-1:0] fetch_idx;
    logic [INDEX-1:0] ex_idx;
    logic [1:0]       bht_cur;
    logic [1:0]       bht_next;
    logic             act;
    logic             is_cond;
    logic             actual_taken;
    logic             target_diff;
    logic             mispredict;
    logic [PC_W-1:0]  next_pc;
    btb_op_e          btb_op;
    logic             unused_pc_in_bits;

    // Fetch only indexes with the word-aligned low bits of its PC.
    assign fetch_idx         = pc_in[INDEX+1:2];
    assign unused_pc_in_bits = ^{pc_in[PC_W-1:INDEX+2], pc_in[1:0]};
    assign bht_taken         = bht[fetch_idx][1];
    assign ex_idx            = ex_pc[INDEX+1:2];
    assign bht_cur           = bht[ex_idx];

    // Decode the EX instruction into its real outcome and the actions it triggers.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        act          = 1'b0;
        is_cond      = 1'b0;
        actual_taken = 1'b0;
        target_diff  = 1'b0;
        mispredict   = 1'b0;
        next_pc      = '0;
        btb_op       = BTB_NONE;
        bht_next     = bht_cur;

        act          = ex_valid & ~ex_flush & ~stall & (ex_is_branch | ex_is_jump);
        // An instruction flagged as both a branch and a jump behaves as a jump.
        is_cond      = ex_is_branch & ~ex_is_jump;
        actual_taken = ex_is_jump | ex_taken;
        target_diff  = (ex_pred_target != ex_target);

        if (actual_taken) begin
            mispredict = ~ex_pred_taken | target_diff;
            next_pc    = ex_target;
        end else begin
            mispredict = ex_pred_taken;
            next_pc    = ex_pc + PC_W'(4);
        end

        // Install or fix the BTB entry when a taken target is not in the BTB.
        // Drop the entry once a cold branch falls through.
        if (actual_taken && (!ex_pred_hit || target_diff)) begin
            btb_op = BTB_WRITE;
        end else if (!actual_taken && ex_pred_hit && is_cond && (bht_cur <= 2'b01)) begin
            btb_op = BTB_CLEAR;
        end

        if (actual_taken) begin
            bht_next = (bht_cur == 2'b11) ? 2'b11 : bht_cur + 2'd1;
        end else begin
            bht_next = (bht_cur == 2'b00) ? 2'b00 : bht_cur - 2'd1;
        end
    end

    // Register the resolved result toward MEM. A non-act cycle cancels only the pulses.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
        if (reset) begin
            ex_mem_pc      <= '0;
            actual_target  <= '0;
            redirect_pc    <= '0;
            update_btb     <= BTB_NONE;
            redirect_valid <= 1'b0;
        end else if (act) begin
            ex_mem_pc      <= ex_pc;
            actual_target  <= ex_target;
            redirect_pc    <= next_pc;
            update_btb     <= btb_op;
            redirect_valid <= mispredict;
        end else begin
            update_btb     <= BTB_NONE;
            redirect_valid <= 1'b0;
        end
    end

    // Train the history table on resolved conditional branches. Jumps leave it alone.
    always_ff @(posedge clk) begin
        // NOTE: this small table is built from flops, so it can be reset; a RAM-backed array could not.
        if (reset) begin
            for (int i = 0; i < ENTRY; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (act && is_cond) begin
            bht[ex_idx] <= bht_next;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (act) begin
            if (branch_count != '1) begin
                branch_count <= branch_count + CNT_W'(1);
            end
            if (mispredict && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit. A behavioural model computes the
// expected registered outputs and BHT state with plain integer arithmetic.
// A compare process checks the DUT against that model on every falling
// edge. Directed steps pin the model with hand-computed literal values.
module tb_branch_resolve_unit;

    localparam int PC_W    = 12;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [PC_W-1:0]  pc_in;
    logic             bht_taken;
    logic             ex_valid, ex_flush, stall, ex_is_branch, ex_is_jump;
    logic [PC_W-1:0]  ex_pc;
    logic             ex_taken;
    logic [PC_W-1:0]  ex_target;
    logic             ex_pred_hit, ex_pred_taken;
    logic [PC_W-1:0]  ex_pred_target;
    logic [PC_W-1:0]  ex_mem_pc;
    logic [1:0]       update_btb;
    logic [PC_W-1:0]  actual_target;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] branch_count, mispredict_count;

    int n_checks = 0;
    int n_pass   = 0;

    branch_resolve_unit #(.ENTRY(32), .INDEX(5), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .bht_taken(bht_taken),
        .ex_valid(ex_valid), .ex_flush(ex_flush), .stall(stall),
        .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_pc(ex_pc),
        .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_hit(ex_pred_hit),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .ex_mem_pc(ex_mem_pc), .update_btb(update_btb), .actual_target(actual_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_bht [32];
    int m_pc, m_tgt, m_rpc, m_upd, m_rv, m_bc, m_mc;
    bit m_ready = 1'b0;

    always @(posedge clk) begin
        int  idx, pre;
        bit  taken, cond, miss;
        if (reset) begin
            foreach (m_bht[i]) m_bht[i] = 1;
            m_pc = 0; m_tgt = 0; m_rpc = 0; m_upd = 0; m_rv = 0; m_bc = 0; m_mc = 0;
            m_ready = 1'b1;
        end else if (ex_valid && !ex_flush && !stall && (ex_is_branch || ex_is_jump)) begin
            idx   = (int'(ex_pc) / 4) % 32;
            pre   = m_bht[idx];
            cond  = ex_is_branch && !ex_is_jump;
            taken = ex_is_jump || ex_taken;
            if (taken) miss = !ex_pred_taken || (ex_pred_target != ex_target);
            else       miss = ex_pred_taken;
            m_pc  = int'(ex_pc);
            m_tgt = int'(ex_target);
            m_rpc = taken ? int'(ex_target) : (int'(ex_pc) + 4) % 4096;
            if (taken && (!ex_pred_hit || ex_pred_target != ex_target)) m_upd = 1;
            else if (!taken && ex_pred_hit && cond && pre <= 1)          m_upd = 2;
            else                                                         m_upd = 0;
            m_rv = miss ? 1 : 0;
            if (cond) m_bht[idx] = taken ? ((pre < 3) ? pre + 1 : 3) : ((pre > 0) ? pre - 1 : 0);
            if (m_bc < CNT_MAX) m_bc++;
            if (miss && m_mc < CNT_MAX) m_mc++;
        end else begin
            m_upd = 0;
            m_rv  = 0;
        end
    end

    // Compare every registered output and the fetch-side read against the model.
    always @(negedge clk) begin
        if (m_ready) begin
            check("ex_mem_pc",        32'(ex_mem_pc),        32'(m_pc));
            check("actual_target",    32'(actual_target),    32'(m_tgt));
            check("redirect_pc",      32'(redirect_pc),      32'(m_rpc));
            check("update_btb",       32'(update_btb),       32'(m_upd));
            check("redirect_valid",   32'(redirect_valid),   32'(m_rv));
            check("branch_count",     32'(branch_count),     32'(m_bc));
            check("mispredict_count", 32'(mispredict_count), 32'(m_mc));
            check("bht_taken",        32'(bht_taken),        32'(m_bht[(int'(pc_in) / 4) % 32] >= 2));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 0; ex_flush = 0; stall = 0; ex_is_branch = 0; ex_is_jump = 0;
        ex_pc = '0; ex_taken = 0; ex_target = '0;
        ex_pred_hit = 0; ex_pred_taken = 0; ex_pred_target = '0;
    endtask

    task automatic drive(input bit br, input bit jmp, input logic [PC_W-1:0] pc,
                         input bit tk, input logic [PC_W-1:0] tgt,
                         input bit hit, input bit ptk, input logic [PC_W-1:0] ptgt);
        ex_valid = 1; ex_flush = 0; stall = 0; ex_is_branch = br; ex_is_jump = jmp;
        ex_pc = pc; ex_taken = tk; ex_target = tgt;
        ex_pred_hit = hit; ex_pred_taken = ptk; ex_pred_target = ptgt;
    endtask

    initial begin
        reset = 1'b1;
        pc_in = '0;
        idle();
        step(); step();
        reset = 1'b0;

        // Reset state: every entry weakly not-taken, all outputs zero.
        for (int i = 0; i < 32; i++) begin
            pc_in = PC_W'(i * 4);
            #2;
            check("reset bht_taken", 32'(bht_taken), 32'd0);
            step();
        end
        check("reset update_btb", 32'(update_btb), 32'd0);
        check("reset redirect_valid", 32'(redirect_valid), 32'd0);
        check("reset branch_count", 32'(branch_count), 32'd0);

        // Cold taken branch: BTB install, redirect to the target, BHT 01 -> 10.
        pc_in = 12'h040;
        drive(1, 0, 12'h040, 1, 12'h080, 0, 0, 12'h000);
        step(); idle();
        check("t2 ex_mem_pc", 32'(ex_mem_pc), 32'h040);
        check("t2 update_btb", 32'(update_btb), 32'd1);
        check("t2 actual_target", 32'(actual_target), 32'h080);
        check("t2 redirect_valid", 32'(redirect_valid), 32'd1);
        check("t2 redirect_pc", 32'(redirect_pc), 32'h080);
        check("t2 bht_taken", 32'(bht_taken), 32'd1);
        check("t2 branch_count", 32'(branch_count), 32'd1);
        check("t2 mispredict_count", 32'(mispredict_count), 32'd1);

        // Correctly predicted twice: no BTB action, no redirect, counter saturates at 11.
        for (int r = 0; r < 2; r++) begin
            drive(1, 0, 12'h040, 1, 12'h080, 1, 1, 12'h080);
            step();
            check("t3 update_btb", 32'(update_btb), 32'd0);
            check("t3 redirect_valid", 32'(redirect_valid), 32'd0);
        end
        idle();
        check("t3 mispredict_count", 32'(mispredict_count), 32'd1);

        // Fall through three times: 11 -> 10 -> 01 -> 00. Only the last step sees pre <= 01.
        for (int r = 0; r < 3; r++) begin
            drive(1, 0, 12'h040, 0, 12'h080, 1, 1, 12'h080);
            step();
            check("t4 redirect_pc", 32'(redirect_pc), 32'h044);
            check("t4 update_btb", 32'(update_btb), (r == 2) ? 32'd2 : 32'd0);
        end
        idle();
        check("t4 bht_taken", 32'(bht_taken), 32'd0);

        // JALR with a stale BTB target: rewrite it, redirect, and leave the BHT alone.
        pc_in = 12'h100;
        drive(0, 1, 12'h100, 0, 12'h200, 1, 1, 12'h1F0);
        step(); idle();
        check("t5 update_btb", 32'(update_btb), 32'd1);
        check("t5 redirect_pc", 32'(redirect_pc), 32'h200);
        check("t5 bht_taken", 32'(bht_taken), 32'd0);
        check("t5 branch_count", 32'(branch_count), 32'd7);
        check("t5 mispredict_count", 32'(mispredict_count), 32'd5);

        // Stall, then flush: no effect at all.
        drive(1, 0, 12'h100, 1, 12'h300, 0, 0, 12'h000);
        stall = 1;
        step();
        check("t6 stall update_btb", 32'(update_btb), 32'd0);
        check("t6 stall redirect_valid", 32'(redirect_valid), 32'd0);
        stall = 0; ex_flush = 1;
        step(); idle();
        check("t6 flush redirect_valid", 32'(redirect_valid), 32'd0);
        check("t6 branch_count", 32'(branch_count), 32'd7);
        check("t6 bht_taken", 32'(bht_taken), 32'd0);

        // Fall-through PC wraps at the top of the address space.
        drive(1, 0, 12'hFFC, 0, 12'h010, 0, 0, 12'h000);
        step(); idle();
        check("wrap redirect_pc", 32'(redirect_pc), 32'h000);
        check("wrap ex_mem_pc", 32'(ex_mem_pc), 32'hFFC);

        // Reset asserted during a redirect cycle clears everything on the next edge.
        drive(1, 0, 12'h040, 1, 12'h0C0, 0, 0, 12'h000);
        step(); idle();
        check("pre-reset redirect_valid", 32'(redirect_valid), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid reset redirect_valid", 32'(redirect_valid), 32'd0);
        check("mid reset redirect_pc", 32'(redirect_pc), 32'd0);
        check("mid reset ex_mem_pc", 32'(ex_mem_pc), 32'd0);
        check("mid reset branch_count", 32'(branch_count), 32'd0);

        // Randomized traffic over a small PC/target pool, so entries alias and predictions sometimes match.
        for (int n = 0; n < 3000; n++) begin
            pc_in          = PC_W'($urandom) & 12'h0FC;
            ex_valid       = ($urandom_range(0, 3) != 0);
            ex_flush       = ($urandom_range(0, 7) == 0);
            stall          = ($urandom_range(0, 7) == 0);
            ex_is_branch   = $urandom_range(0, 1);
            ex_is_jump     = ($urandom_range(0, 3) == 0);
            ex_pc          = ($urandom_range(0, 15) == 0) ? 12'hFFC : (PC_W'($urandom) & 12'h01C);
            ex_taken       = $urandom_range(0, 1);
            ex_target      = $urandom_range(0, 1) ? 12'h400 : 12'h800;
            ex_pred_hit    = $urandom_range(0, 1);
            ex_pred_taken  = $urandom_range(0, 1);
            ex_pred_target = $urandom_range(0, 1) ? 12'h400 : 12'h800;
            step();
        end

        // Drive both counters into saturation.
        for (int n = 0; n < CNT_MAX + 40; n++) begin
            drive(1, 0, 12'h020, 1, 12'h300, 0, 0, 12'h000);
            step();
        end
        idle();
        check("sat branch_count", 32'(branch_count), 32'(CNT_MAX));
        check("sat mispredict_count", 32'(mispredict_count), 32'(CNT_MAX));
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
